// File: rtl/xcvr_reset_sequencer.sv
// Transceiver PHY reset sequencer.
// Releases pll_powerdown, tx/rx analog and tx/rx digital resets in order,
// based on calibration, PLL-lock and CDR-lock status. TX and RX have
// independent FSMs. Every PHY reset and ready flag comes from a flop that
// is loaded with the decode of the next state, so it changes on the same
// edge as the state.
// There is no valid/ready handshake. tx_reset_req and rx_reset_req are
// single-cycle request pulses that are acted on at the next clock edge.
// Status inputs go through 2-flop synchronizers, so a level change is
// acted on at the second edge after the edge that first samples it.
module xcvr_reset_sequencer #(
    parameter int T_PLL_PD     = 50,
    parameter int T_LTD        = 250,
    parameter int T_PLL_STABLE = 16,
    parameter int CNT_W        = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tx_reset_req,
    input  logic       rx_reset_req,
    input  logic       pll_locked,
    input  logic       tx_cal_busy,
    input  logic       rx_cal_busy,
    input  logic       rx_is_lockedtodata,
    input  logic       SFP_LOS,
    output logic       pll_powerdown,
    output logic       tx_analogreset,
    output logic       tx_digitalreset,
    output logic       rx_analogreset,
    output logic       rx_digitalreset,
    output logic       tx_ready,
    output logic       rx_ready,
    output logic [1:0] o_tx_state,
    output logic [1:0] o_rx_state
);

    typedef enum logic [1:0] {
        TX_RESET     = 2'd0,
        TX_WAIT_CAL  = 2'd1,
        TX_WAIT_LOCK = 2'd2,
        TX_READY     = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_RESET    = 2'd0,
        RX_WAIT_LTD = 2'd1,
        RX_READY    = 2'd2
    } rx_state_t;

    // Last count value of each dwell; the transition happens on that edge.
    localparam logic [CNT_W-1:0] C_PD_LAST  = CNT_W'(T_PLL_PD - 1);
    localparam logic [CNT_W-1:0] C_PLL_LAST = CNT_W'(T_PLL_STABLE - 1);
    localparam logic [CNT_W-1:0] C_LTD_LAST = CNT_W'(T_LTD - 1);

    // Synchronizer bit order: {los, ltd, rx_cal, tx_cal, locked}.
    // They reset to the pessimistic levels: LOS, cal busy, not locked.
    localparam logic [4:0] C_SYNC_RST = 5'b10110;

    logic [4:0]       r_sync1, r_sync2;
    tx_state_t        r_tx_state, w_tx_state_nxt;
    rx_state_t        r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic             w_locked, w_tx_cal, w_rx_cal, w_ltd, w_los, w_rx_good;
    logic             w_pd, w_ta, w_td, w_ra, w_rd, w_txr, w_rxr;

    assign {w_los, w_ltd, w_rx_cal, w_tx_cal, w_locked} = r_sync2;
    assign w_rx_good  = w_ltd & ~w_los;
    assign o_tx_state = r_tx_state;
    assign o_rx_state = r_rx_state;

    // Two-flop synchronizers for the asynchronous status inputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= C_SYNC_RST;
            r_sync2 <= C_SYNC_RST;
        end else begin
            r_sync1 <= {SFP_LOS, rx_is_lockedtodata, rx_cal_busy, tx_cal_busy, pll_locked};
            r_sync2 <= r_sync1;
        end
    end

    // State and dwell counter registers for both FSMs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_state <= TX_RESET;
            r_rx_state <= RX_RESET;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_rx_state <= w_rx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
        end
    end

    // TX next state. A request restarts the power-down dwell from zero,
    // even when the FSM is already in TX_RESET.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        if (tx_reset_req) begin
            w_tx_state_nxt = TX_RESET;
            w_tx_cnt_nxt   = '0;
        end else begin
            case (r_tx_state)
                TX_RESET: begin
                    if (r_tx_cnt >= C_PD_LAST) begin
                        w_tx_state_nxt = TX_WAIT_CAL;
                        w_tx_cnt_nxt   = '0;
                    end else begin
                        w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                    end
                end
                TX_WAIT_CAL: begin
                    if (!w_tx_cal) begin
                        w_tx_state_nxt = TX_WAIT_LOCK;
                        w_tx_cnt_nxt   = '0;
                    end
                end
                TX_WAIT_LOCK: begin
                    if (!w_locked) begin
                        w_tx_cnt_nxt = '0;
                    end else if (r_tx_cnt >= C_PLL_LAST) begin
                        w_tx_state_nxt = TX_READY;
                        w_tx_cnt_nxt   = '0;
                    end else begin
                        w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                    end
                end
                TX_READY: begin
                    if (!w_locked) begin
                        w_tx_state_nxt = TX_WAIT_LOCK;
                        w_tx_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_tx_state_nxt = TX_RESET;
                    w_tx_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // RX next state. A TX restart powers the PLL down, so RX is restarted
    // with it. RX leaves reset only once TX has released pll_powerdown.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        if (tx_reset_req || rx_reset_req) begin
            w_rx_state_nxt = RX_RESET;
            w_rx_cnt_nxt   = '0;
        end else begin
            case (r_rx_state)
                RX_RESET: begin
                    w_rx_cnt_nxt = '0;
                    if ((r_tx_state != TX_RESET) && !w_rx_cal) begin
                        w_rx_state_nxt = RX_WAIT_LTD;
                    end
                end
                RX_WAIT_LTD: begin
                    if (!w_rx_good) begin
                        w_rx_cnt_nxt = '0;
                    end else if (r_rx_cnt >= C_LTD_LAST) begin
                        w_rx_state_nxt = RX_READY;
                        w_rx_cnt_nxt   = '0;
                    end else begin
                        w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                    end
                end
                RX_READY: begin
                    if (!w_rx_good) begin
                        w_rx_state_nxt = RX_WAIT_LTD;
                        w_rx_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_rx_state_nxt = RX_RESET;
                    w_rx_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode of the next state. The release order is built into
    // the states: each later reset is held in every state where an
    // earlier reset is still held.
    always_comb begin
        w_pd  = (w_tx_state_nxt == TX_RESET);
        w_ta  = (w_tx_state_nxt == TX_RESET) || (w_tx_state_nxt == TX_WAIT_CAL);
        w_td  = (w_tx_state_nxt != TX_READY);
        w_txr = (w_tx_state_nxt == TX_READY);
        w_ra  = (w_rx_state_nxt == RX_RESET);
        w_rd  = (w_rx_state_nxt != RX_READY);
        w_rxr = (w_rx_state_nxt == RX_READY);
    end

    // Output flops that drive the PHY resets and the ready flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pll_powerdown   <= 1'b1;
            tx_analogreset  <= 1'b1;
            tx_digitalreset <= 1'b1;
            rx_analogreset  <= 1'b1;
            rx_digitalreset <= 1'b1;
            tx_ready        <= 1'b0;
            rx_ready        <= 1'b0;
        end else begin
            pll_powerdown   <= w_pd;
            tx_analogreset  <= w_ta;
            tx_digitalreset <= w_td;
            rx_analogreset  <= w_ra;
            rx_digitalreset <= w_rd;
            tx_ready        <= w_txr;
            rx_ready        <= w_rxr;
        end
    end

endmodule
